// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO between uart_rx and uart_interface.
// Buffers received bytes while the interface is busy, so back-to-back UART bytes are
// not lost. A push into a full FIFO is dropped and sets a sticky overflow flag.
// A pop while full makes room for a push in the same cycle.
// Optional feature: define RX_FIFO_ALMOST_FULL_EN to add the registered o_almost_full port.
module uart_rx_fifo #(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ALMOST_THR = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic [NB_DATA-1:0]    i_wr_data,
    input  logic                  i_rd,
    input  logic                  i_clr_ovf,
    output logic [NB_DATA-1:0]    o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    output logic                  o_almost_full
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ALMOST_THR_C = ALMOST_THR[DEPTH_LOG2:0];

    logic [NB_DATA-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop, ovf_set;

    assign o_empty    = (count_q == '0);
    assign o_full     = (count_q == DEPTH_C);
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_rd_data  = o_empty ? '0 : mem[rd_ptr_q];

    // Accept/drop decisions and next-state for pointers, count and overflow flag
    always_comb begin
        pop      = i_rd && !o_empty;
        // When full, a simultaneous pop frees the slot being written
        push     = i_wr && (!o_full || i_rd);
        ovf_set  = i_wr && o_full && !i_rd;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set wins over a same-cycle clear
        overflow_d = ovf_set ? 1'b1 : (i_clr_ovf ? 1'b0 : overflow_q);
    end

    // Control state with asynchronous reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

`ifdef RX_FIFO_ALMOST_FULL_EN
    logic almost_full_q;

    // Registered almost-full, evaluated on the count after this edge
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= ALMOST_THR_C);
        end
    end

    assign o_almost_full = almost_full_q;
`else
    logic unused_almost_thr;
    assign unused_almost_thr = ^ALMOST_THR_C;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo at depth 4 with a data scoreboard.
// Pass RX_FIFO_ALMOST_FULL_EN to also cover o_almost_full.
module tb_uart_rx_fifo;

    localparam int unsigned NB_DATA    = 8;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned ALMOST_THR = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr = 1'b0;
    logic [NB_DATA-1:0]  wr_data = '0;
    logic                rd = 1'b0;
    logic                clr_ovf = 1'b0;
    logic [NB_DATA-1:0]  rd_data;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
`ifdef RX_FIFO_ALMOST_FULL_EN
    logic                almost_full;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [NB_DATA-1:0] sb[$];

    uart_rx_fifo #(
        .NB_DATA   (NB_DATA),
        .DEPTH_LOG2(DEPTH_LOG2),
        .ALMOST_THR(ALMOST_THR)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_wr         (wr),
        .i_wr_data    (wr_data),
        .i_rd         (rd),
        .i_clr_ovf    (clr_ovf),
        .o_rd_data    (rd_data),
        .o_empty      (empty),
        .o_full       (full),
        .o_count      (count),
        .o_overflow   (overflow)
`ifdef RX_FIFO_ALMOST_FULL_EN
        ,
        .o_almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle with the given strobes; returns at posedge+1
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr = w;
        wr_data = d;
        rd = r;
        clr_ovf = c;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        clr_ovf = 1'b0;
    endtask

    // Monitor: every accepted pop must present the next expected byte
    always @(negedge clk) begin
        if (rst_n && rd && !empty) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", {24'h0, rd_data}, 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", {24'h0, rd_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1 Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // 2 Order
        cyc(1'b1, 8'h11, 1'b0, 1'b0); sb.push_back(8'h11);
        chk("fwft_first", 32'(rd_data), 32'h11);
        cyc(1'b1, 8'h22, 1'b0, 1'b0); sb.push_back(8'h22);
        cyc(1'b1, 8'h33, 1'b0, 1'b0); sb.push_back(8'h33);
        chk("order_count3", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("order_empty", 32'(empty), 32'd1);

        // 3 Full / overflow
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            sb.push_back(8'hA0 + 8'(i));
        end
        chk("full_after4", 32'(full), 32'd1);
        chk("no_ovf_yet", 32'(overflow), 32'd0);
        cyc(1'b1, 8'hA4, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // 4 Simultaneous at full and at empty
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
            sb.push_back(8'hB0 + 8'(i));
        end
        cyc(1'b1, 8'h55, 1'b1, 1'b0); sb.push_back(8'h55);
        chk("sim_full_count", 32'(count), 32'd4);
        chk("sim_full_no_ovf", 32'(overflow), 32'd0);
        // Overflow and clear in the same cycle: set wins
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear2", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sim_drained", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_empty_count", 32'(count), 32'd0);
        chk("pop_empty_no_flag", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h66, 1'b1, 1'b0); sb.push_back(8'h66);
        chk("sim_empty_count", 32'(count), 32'd1);
        chk("sim_empty_data", 32'(rd_data), 32'h66);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // 5 Wrap: push/pop pairs across pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0); sb.push_back(8'(i));
            chk("wrap_count_push", 32'(count), 32'd1);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_count_pop", 32'(count), 32'd0);
        end

        // 6 Async reset mid-operation
        cyc(1'b1, 8'hC0, 1'b0, 1'b0);
        cyc(1'b1, 8'hC1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
`ifdef RX_FIFO_ALMOST_FULL_EN
        chk("almost_full_at3", 32'(almost_full), 32'd1);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_rd_data", 32'(rd_data), 32'h00);
        chk("async_rst_full", 32'(full), 32'd0);
`ifdef RX_FIFO_ALMOST_FULL_EN
        chk("async_rst_almost", 32'(almost_full), 32'd0);
`endif
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_empty", 32'(empty), 32'd1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
